// File: rtl/trig_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : trig_issue_if
//  Purpose  : Trigger request / issued-trigger bundle between a trigger
//             source, the trigger issuer and the buffer tracker.
//  Signals  : trig_req_i  - raw trigger request, one cycle per request
//             dead_i      - buffer tracker deadtime flag
//             trig_o      - issued trigger pulse
//             trig_addr_o - buffer address of the issued trigger
//             trig_num_o  - event number of the issued trigger
//  Revision : 1.0  initial release
// ============================================================================
interface trig_issue_if;
    logic        trig_req_i;
    logic        dead_i;
    logic        trig_o;
    logic [1:0]  trig_addr_o;
    logic [31:0] trig_num_o;

    // master: trigger source / bench side
    modport master (
        output trig_req_i,
        output dead_i,
        input  trig_o,
        input  trig_addr_o,
        input  trig_num_o
    );

    // slave: trigger issuer side
    modport slave (
        input  trig_req_i,
        input  dead_i,
        output trig_o,
        output trig_addr_o,
        output trig_num_o
    );
endinterface
`default_nettype wire

// File: rtl/trig_issue.sv
`default_nettype none
// ============================================================================
//  Module   : trig_issue
//  Purpose  : Accepts raw trigger requests while a run is active, enforces a
//             programmable holdoff after each accepted trigger, rejects
//             requests during deadtime, and issues a one-cycle trigger pulse
//             tagged with a buffer address and event number.
//  Ports    : sys_clk_i     - system clock
//             sys_rst_n_i   - asynchronous active-low reset
//             runrst_i      - run reset pulse (start run, clear counters)
//             runstop_i     - run stop pulse
//             holdoff_i     - holdoff length in cycles, sampled at acceptance
//             trig_bus      - request/deadtime in, trigger/address/number out
//             running_o     - run active
//             rej_dead_o    - saturating count of deadtime rejections
//             rej_holdoff_o - saturating count of holdoff rejections
//  Revision : 1.0  initial release
// ============================================================================
module trig_issue #(
    parameter int HOLDOFF_W = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_n_i,
    input  logic                 runrst_i,
    input  logic                 runstop_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    trig_issue_if.slave          trig_bus,
    output logic                 running_o,
    output logic [31:0]          rej_dead_o,
    output logic [31:0]          rej_holdoff_o
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Reset: assertion passes straight through the async clear of the
    // synchroniser; deassertion is released on a clock edge so every
    // downstream flop leaves reset on the same edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HOLDOFF_W-1:0]  r_hold_cnt;
    logic [HOLDOFF_W-1:0]  w_hold_cnt_nxt;
    logic                  w_accept;
    logic                  w_rej_dead;
    logic                  w_rej_hold;
    logic                  r_trig;
    logic [1:0]            r_addr;
    logic [31:0]           r_num;
    logic [31:0]           r_rej_dead;
    logic [31:0]           r_rej_hold;

    // State register
    always_ff @(posedge sys_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_STOPPED;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Next state and per-request decisions. Run control pulses swallow any
    // request presented in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_accept       = 1'b0;
        w_rej_dead     = 1'b0;
        w_rej_hold     = 1'b0;

        if (runrst_i) begin
            w_state_nxt = ST_ARMED;
        end else if (runstop_i) begin
            w_state_nxt = ST_STOPPED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (trig_bus.trig_req_i) begin
                        if (trig_bus.dead_i) begin
                            w_rej_dead = 1'b1;
                        end else begin
                            w_accept = 1'b1;
                            if (holdoff_i != '0) begin
                                w_state_nxt    = ST_HOLDOFF;
                                w_hold_cnt_nxt = holdoff_i;
                            end
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // Counter holds the number of blocked cycles remaining,
                    // including the current one.
                    w_rej_hold = trig_bus.trig_req_i;
                    if (r_hold_cnt <= HOLDOFF_W'(1)) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Trigger pulse, tags and rejection counters. Address and number show
    // the tag of the pulse currently on trig_o and advance once it ends.
    always_ff @(posedge sys_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_trig     <= 1'b0;
            r_addr     <= 2'd0;
            r_num      <= 32'd0;
            r_rej_dead <= 32'd0;
            r_rej_hold <= 32'd0;
        end else begin
            r_trig <= w_accept;
            if (runrst_i) begin
                r_addr     <= 2'd0;
                r_num      <= 32'd0;
                r_rej_dead <= 32'd0;
                r_rej_hold <= 32'd0;
            end else begin
                if (r_trig) begin
                    r_addr <= r_addr + 2'd1;
                    r_num  <= r_num + 32'd1;
                end
                if (w_rej_dead && (r_rej_dead != 32'hFFFF_FFFF)) begin
                    r_rej_dead <= r_rej_dead + 32'd1;
                end
                if (w_rej_hold && (r_rej_hold != 32'hFFFF_FFFF)) begin
                    r_rej_hold <= r_rej_hold + 32'd1;
                end
            end
        end
    end

    assign trig_bus.trig_o      = r_trig;
    assign trig_bus.trig_addr_o = r_addr;
    assign trig_bus.trig_num_o  = r_num;
    assign running_o            = (r_state != ST_STOPPED);
    assign rej_dead_o           = r_rej_dead;
    assign rej_holdoff_o        = r_rej_hold;

endmodule
`default_nettype wire

// File: tb/tb_trig_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trig_issue
//  Purpose  : Self-checking bench for trig_issue. A cycle-level reference
//             model predicts each issued trigger into a queue; a monitor
//             compares pulses and run/counter outputs every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trig_issue;

    localparam int HW = 16;

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_n_i;
    logic          runrst_i;
    logic          runstop_i;
    logic [HW-1:0] holdoff_i;
    logic          running_o;
    logic [31:0]   rej_dead_o;
    logic [31:0]   rej_holdoff_o;

    always #5 sys_clk_i = ~sys_clk_i;

    trig_issue_if bus ();

    trig_issue #(.HOLDOFF_W(HW)) dut (
        .sys_clk_i     (sys_clk_i),
        .sys_rst_n_i   (sys_rst_n_i),
        .runrst_i      (runrst_i),
        .runstop_i     (runstop_i),
        .holdoff_i     (holdoff_i),
        .trig_bus      (bus),
        .running_o     (running_o),
        .rej_dead_o    (rej_dead_o),
        .rej_holdoff_o (rej_holdoff_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [1:0]  addr;
        logic [31:0] num;
    } exp_t;

    exp_t        q[$];
    int          cyc   = 0;
    bit          m_run = 0;
    bit          m_win = 0;   // a holdoff window is open from an acceptance
    int          m_acc = 0;   // cycle of last acceptance
    int          m_hold = 0;  // holdoff captured at that acceptance
    logic [31:0] m_num = 0;   // triggers issued since runrst
    logic [31:0] m_rd  = 0;
    logic [31:0] m_rh  = 0;
    bit          mon_en = 0;
    int          n_trig = 0;

    task automatic model_reset();
        m_run = 0; m_win = 0; m_num = 0; m_rd = 0; m_rh = 0;
        q.delete();
    endtask

    // Start at a negedge: apply inputs, let one rising edge consume them,
    // advance the model, end at the following negedge.
    task automatic step(bit rr, bit rs, bit req, bit dead);
        runrst_i       = rr;
        runstop_i      = rs;
        bus.trig_req_i = req;
        bus.dead_i     = dead;
        @(posedge sys_clk_i);
        if (rr) begin
            m_run = 1; m_win = 0; m_num = 0; m_rd = 0; m_rh = 0;
        end else if (rs) begin
            m_run = 0; m_win = 0;
        end else if (m_run && req) begin
            if (m_win && (cyc - m_acc) <= m_hold) begin
                if (m_rh != 32'hFFFF_FFFF) m_rh = m_rh + 1;
            end else if (dead) begin
                if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
            end else begin
                q.push_back('{due: cyc + 1, addr: m_num[1:0], num: m_num});
                m_num  = m_num + 1;
                m_acc  = cyc;
                m_hold = int'(holdoff_i);
                m_win  = (holdoff_i != 0);
            end
        end
        cyc++;
        @(negedge sys_clk_i);
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk_i) begin
        exp_t e;
        if (mon_en) begin
            check("running", 32'(running_o), 32'(m_run));
            check("rej_dead", rej_dead_o, m_rd);
            check("rej_holdoff", rej_holdoff_o, m_rh);
            if (bus.trig_o) begin
                n_trig++;
                if (q.size() == 0) begin
                    check("unexpected_trig", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("trig_cycle", 32'(cyc), 32'(e.due));
                    check("trig_addr", 32'(bus.trig_addr_o), 32'(e.addr));
                    check("trig_num", bus.trig_num_o, e.num);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                check("missing_trig", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        sys_rst_n_i    = 1'b0;
        runrst_i       = 1'b0;
        runstop_i      = 1'b0;
        holdoff_i      = '0;
        bus.trig_req_i = 1'b0;
        bus.dead_i     = 1'b0;

        repeat (3) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        check("rst_running", 32'(running_o), 32'd0);
        check("rst_trig", 32'(bus.trig_o), 32'd0);
        check("rst_addr", 32'(bus.trig_addr_o), 32'd0);
        check("rst_num", bus.trig_num_o, 32'd0);
        check("rst_rej_dead", rej_dead_o, 32'd0);
        check("rst_rej_hold", rej_holdoff_o, 32'd0);
        sys_rst_n_i = 1'b1;
        repeat (4) @(negedge sys_clk_i);
        mon_en = 1;

        // Idle after reset: requests ignored, nothing counted
        t0 = n_trig;
        repeat (10) step(0, 0, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("s1_trigs", 32'(n_trig - t0), 32'd0);
        check("s1_rej_dead", rej_dead_o, 32'd0);
        check("s1_rej_hold", rej_holdoff_o, 32'd0);

        // Back-to-back with no holdoff
        holdoff_i = 0;
        step(1, 0, 0, 0);
        t0 = n_trig;
        repeat (6) step(0, 0, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("s2_trigs", 32'(n_trig - t0), 32'd6);
        check("s2_num_after", bus.trig_num_o, 32'd6);
        check("s2_addr_after", 32'(bus.trig_addr_o), 32'd2);

        // Holdoff of 3 with requests on five consecutive cycles
        holdoff_i = 3;
        step(1, 0, 0, 0);
        t0 = n_trig;
        repeat (5) step(0, 0, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("s3_trigs", 32'(n_trig - t0), 32'd2);
        check("s3_rej_hold", rej_holdoff_o, 32'd3);

        // Deadtime rejections, then one clean request
        holdoff_i = 0;
        step(1, 0, 0, 0);
        t0 = n_trig;
        repeat (5) step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("s4_rej_dead", rej_dead_o, 32'd5);
        check("s4_no_trig", 32'(n_trig - t0), 32'd0);
        step(0, 0, 1, 0);
        check("s4_trig", 32'(bus.trig_o), 32'd1);
        check("s4_addr", 32'(bus.trig_addr_o), 32'd0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);

        // Runstop right after acceptance keeps the scheduled pulse
        step(1, 0, 0, 0);
        t0 = n_trig;
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("s5_running", 32'(running_o), 32'd0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("s5_trigs", 32'(n_trig - t0), 32'd1);
        step(1, 0, 0, 0);
        check("s5_num_clr", bus.trig_num_o, 32'd0);
        check("s5_addr_clr", 32'(bus.trig_addr_o), 32'd0);
        check("s5_rej_clr", rej_dead_o | rej_holdoff_o, 32'd0);

        // Asynchronous reset in the middle of a holdoff
        holdoff_i = 5;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        #2;
        mon_en = 0;
        sys_rst_n_i = 1'b0;
        #1;
        check("ar_running", 32'(running_o), 32'd0);
        check("ar_trig", 32'(bus.trig_o), 32'd0);
        check("ar_num", bus.trig_num_o, 32'd0);
        check("ar_addr", 32'(bus.trig_addr_o), 32'd0);
        check("ar_rej", rej_dead_o | rej_holdoff_o, 32'd0);
        model_reset();
        @(negedge sys_clk_i);
        sys_rst_n_i = 1'b1;
        repeat (4) @(negedge sys_clk_i);
        mon_en = 1;
        t0 = n_trig;
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("ar_stopped", 32'(running_o), 32'd0);
        check("ar_no_trig", 32'(n_trig - t0), 32'd0);

        // Randomised traffic against the model
        step(1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) holdoff_i = HW'($urandom_range(0, 4));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25);
        end
        repeat (3) step(0, 0, 0, 0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trig_issue.md
TRIG_ISSUE -- requirements
Module: trig_issue

Interface
REQ-001 The module SHALL have parameter HOLDOFF_W, default 16, giving the width of the holdoff interval in sys_clk cycles.
REQ-002 The module SHALL have these ports:
- sys_clk_i  in  1  system clock; the only clock.
- sys_rst_n_i  in  1  reset; asynchronous, active-low.
- runrst_i  in  1  run reset pulse.
- runstop_i  in  1  run stop pulse.
- trig_req_i  in  1  raw trigger request, one cycle per request.
- dead_i  in  1  buffer tracker deadtime flag.
- holdoff_i  in  HOLDOFF_W  minimum spacing after an accepted trigger; quasi-static.
- trig_o  out  1  issued trigger pulse; feeds the buffer tracker trigger input.
- trig_addr_o  out  2  buffer address of the issued trigger.
- trig_num_o  out  32  event number of the issued trigger.
- running_o  out  1  run active.
- rej_dead_o  out  32  requests rejected for deadtime.
- rej_holdoff_o  out  32  requests rejected for holdoff.

Function
REQ-003 The FSM SHALL have three states: STOPPED, ARMED and HOLDOFF.
REQ-004 runrst_i SHALL move the FSM from any state to ARMED, and SHALL take priority over runstop_i in the same cycle.
REQ-005 runstop_i without runrst_i SHALL move the FSM from any state to STOPPED.
REQ-006 running_o SHALL be 1 in ARMED and HOLDOFF, and 0 in STOPPED.
REQ-007 In ARMED, trig_req_i=1 with dead_i=0 SHALL be accepted:
- Accepted means trig_o=1 for exactly one cycle, in the cycle after the request (latency 1).
- trig_addr_o and trig_num_o SHALL be valid in the same cycle as trig_o.
REQ-008 On acceptance, if holdoff_i is nonzero the FSM SHALL enter HOLDOFF; if holdoff_i=0 it SHALL stay in ARMED.
REQ-009 Holdoff timing: for a request accepted at cycle N:
- requests at cycles N+1 through N+holdoff_i SHALL be rejected;
- a request at cycle N+holdoff_i+1 SHALL be eligible;
- holdoff_i SHALL be sampled only at acceptance.
REQ-010 Rejection counting:
- A request in HOLDOFF SHALL increment rej_holdoff_o, regardless of dead_i.
- A request in ARMED with dead_i=1 SHALL increment rej_dead_o.
- Each rejected request SHALL increment exactly one counter.
REQ-011 Both rejection counters SHALL saturate at 0xFFFFFFFF.
REQ-012 trig_num_o SHALL increment by 1 after each issued trigger, wrapping from 0xFFFFFFFF to 0.
REQ-013 trig_addr_o SHALL advance modulo 4 after each issued trigger (3 wraps to 0).
REQ-014 runrst_i SHALL clear trig_num_o, trig_addr_o, rej_dead_o and rej_holdoff_o to 0.
REQ-015 A request in the same cycle as runrst_i or runstop_i SHALL be ignored: no trigger issued, no counter incremented.
REQ-016 In STOPPED, requests SHALL be ignored and not counted.
REQ-017 runstop_i SHALL NOT suppress a trig_o pulse already scheduled by an acceptance in the previous cycle.
REQ-018 dead_i SHALL be sampled in the cycle the request is presented; no lookahead is applied.

Reset
REQ-019 While sys_rst_n_i=0, the block SHALL hold:
- state = STOPPED;
- trig_o = 0, trig_addr_o = 0, trig_num_o = 0;
- running_o = 0, rej_dead_o = 0, rej_holdoff_o = 0.
REQ-020 Reset assertion SHALL take effect immediately (asynchronous).
REQ-021 Reset deassertion SHALL be synchronised internally so that all state leaves reset on the same sys_clk_i edge.
REQ-022 After reset deassertion, the block SHALL stay in STOPPED until runrst_i is asserted.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Idle after reset, 10 requests, no runrst -> trig_o never asserted; all counters 0.
- runrst, holdoff_i=0, dead_i=0, 6 back-to-back requests -> 6 trig_o pulses, each 1 cycle after its request; addr 0,1,2,3,0,1; num 0..5.
- runrst, holdoff_i=3, requests at cycles 0,1,2,3,4 -> triggers issued for cycles 0 and 4; rej_holdoff_o=3.
- dead_i=1, 5 requests in ARMED -> no trig_o; rej_dead_o=5. Then dead_i=0 with one request -> trig_o with addr 0.
- runstop_i in the cycle after an accepted request -> trig_o still pulses once, running_o=0; later requests ignored. Then runrst_i -> num=0, addr=0, counters 0.
- sys_rst_n_i low mid-HOLDOFF -> all outputs 0 immediately; after release, state STOPPED.
